// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM access arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_AW = 2;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic. Purely combinational; the caller owns
// the priority pointer and advances it after each grant.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    rr_ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant: a lone requester always wins, a tie goes to rr_ptr.
  always_comb begin
    gnt = '0;
    if (en) begin
      if (&req) begin
        gnt = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one synchronous single-port RAM between two valid/ready requesters.
// Writes retire in the cycle after the handshake; reads answer with a
// one-cycle rsp_valid pulse three cycles after the handshake.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_write_enable,
  input  logic [DW-1:0] ram_data_out
);

  state_t     state;
  req_id_t    rr_ptr;
  req_id_t    lat_id;
  logic       lat_we;
  logic [1:0] gnt;
  logic       arb_en;

  // Grants only exist in IDLE; ready is also held low while reset is asserted.
  assign arb_en = (state == IDLE) && rst_n;

  rr_arbiter2 u_rr_arbiter2 (
    .req    ({req1_valid, req0_valid}),
    .rr_ptr (rr_ptr),
    .en     (arb_en),
    .gnt    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Access sequencer: accept, drive RAM, capture read data, pulse response.
  // The accepted address/write data are latched straight into the RAM drive
  // registers, so they appear on the RAM pins in ACCESS and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= 1'b0;
      lat_id           <= 1'b0;
      lat_we           <= 1'b0;
      rsp0_valid       <= 1'b0;
      rsp1_valid       <= 1'b0;
      rsp0_rdata       <= '0;
      rsp1_rdata       <= '0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ram_write_enable <= 1'b0;
    end else begin
      rsp0_valid       <= 1'b0;
      rsp1_valid       <= 1'b0;
      ram_write_enable <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            lat_id           <= gnt[1];
            lat_we           <= gnt[1] ? req1_we : req0_we;
            ram_address      <= gnt[1] ? req1_addr : req0_addr;
            ram_data_in      <= gnt[1] ? req1_wdata : req0_wdata;
            ram_write_enable <= gnt[1] ? req1_we : req0_we;
            rr_ptr           <= ~gnt[1];
            state            <= ACCESS;
          end
        end
        ACCESS: begin
          state <= lat_we ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          if (lat_id) begin
            rsp1_rdata <= ram_data_out;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_rdata <= ram_data_out;
            rsp0_valid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: drives both requesters cycle by cycle and
// predicts every output from an access-level model (memory array, tie
// preference, and the fixed write/read completion times).
module tb_ram_access_arbiter;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_write_enable;
  logic [DW-1:0] ram_data_out;

  logic [DW-1:0] ram_mem [4];

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
    ram_data_out <= ram_mem[ram_address];
  end

  ram_access_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req0_valid       (req0_valid),
    .req0_ready       (req0_ready),
    .req0_we          (req0_we),
    .req0_addr        (req0_addr),
    .req0_wdata       (req0_wdata),
    .rsp0_valid       (rsp0_valid),
    .rsp0_rdata       (rsp0_rdata),
    .req1_valid       (req1_valid),
    .req1_ready       (req1_ready),
    .req1_we          (req1_we),
    .req1_addr        (req1_addr),
    .req1_wdata       (req1_wdata),
    .rsp1_valid       (rsp1_valid),
    .rsp1_rdata       (rsp1_rdata),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Access-level model
  logic [DW-1:0] mmem [4];
  logic [DW-1:0] exp_rd [2];
  logic          pref;
  int            free_at, we_cyc, acc_cyc, rsp_cyc;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  logic          rsp_id;
  logic [DW-1:0] rsp_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_at   = 0;
    we_cyc    = -1;
    acc_cyc   = -1;
    rsp_cyc   = -1;
    pref      = 1'b0;
    rsp_id    = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One clock: check registered outputs after the edge, apply new inputs,
  // check the combinational ready and advance the model on a handshake.
  task automatic cycle(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output logic hs0, output logic hs1);
    logic          g_any, g, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(posedge clk);
    #2;
    cyc++;
    chk("ram_we", 32'(ram_write_enable), 32'(cyc == we_cyc));
    if (cyc == acc_cyc) begin
      chk("ram_addr", 32'(ram_address), 32'(acc_addr));
      if (acc_we) chk("ram_din", 32'(ram_data_in), 32'(acc_data));
    end
    if (cyc == rsp_cyc) exp_rd[rsp_id] = rsp_val;
    chk("rsp0_valid", 32'(rsp0_valid), 32'(cyc == rsp_cyc && rsp_id == 1'b0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(cyc == rsp_cyc && rsp_id == 1'b1));
    chk("rsp0_rdata", 32'(rsp0_rdata), 32'(exp_rd[0]));
    chk("rsp1_rdata", 32'(rsp1_rdata), 32'(exp_rd[1]));
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    #1;
    g_any = rst_n && (cyc >= free_at) && (v0 || v1);
    g     = (v0 && v1) ? pref : v1;
    hs0   = g_any && !g;
    hs1   = g_any && g;
    chk("ready0", 32'(req0_ready), 32'(hs0));
    chk("ready1", 32'(req1_ready), 32'(hs1));
    if (g_any) begin
      pref     = !g;
      a        = g ? a1 : a0;
      w        = g ? w1 : w0;
      d        = g ? d1 : d0;
      acc_cyc  = cyc + 1;
      acc_addr = a;
      acc_we   = w;
      acc_data = d;
      if (w) begin
        mmem[a] = d;
        we_cyc  = cyc + 1;
        free_at = cyc + 2;
      end else begin
        rsp_val = mmem[a];
        rsp_id  = g;
        rsp_cyc = cyc + 3;
        free_at = cyc + 4;
      end
    end
  endtask

  task automatic idle(input int n);
    logic h0, h1;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 8'd0, h0, h1);
  endtask

  task automatic req_one(input logic id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic h0, h1;
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (!id) cycle(1'b1, w, a, d, 1'b0, 1'b0, 2'd0, 8'd0, h0, h1);
      else     cycle(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, w, a, d, h0, h1);
      done = id ? h1 : h0;
    end
    chk("req_one_granted", 32'(done), 32'd1);
  endtask

  task automatic pair(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      output logic first);
    logic v0, v1, h0, h1, got;
    v0 = 1'b1; v1 = 1'b1; got = 1'b0; first = 1'b0;
    for (int i = 0; i < 20 && (v0 || v1); i++) begin
      cycle(v0, w0, a0, d0, v1, w1, a1, d1, h0, h1);
      if ((h0 || h1) && !got) begin
        first = h1;
        got   = 1'b1;
      end
      if (h0) v0 = 1'b0;
      if (h1) v1 = 1'b0;
    end
    chk("pair_both_granted", 32'(v0 | v1), 32'd0);
  endtask

  task automatic stream(input int n, input logic en0, input logic en1, input logic w,
                        input logic [AW-1:0] base0, input logic [AW-1:0] base1);
    int            k0, k1, cnt, last_hs;
    logic          last_id, h0, h1;
    logic [DW-1:0] d0, d1;
    k0 = 0; k1 = 0; cnt = 0; last_hs = 0; last_id = 1'b0;
    d0 = 8'($urandom); d1 = 8'($urandom);
    for (int i = 0; i < n * 5 + 10 && cnt < n; i++) begin
      cycle(en0, w, 2'(int'(base0) + k0), d0, en1, w, 2'(int'(base1) + k1), d1, h0, h1);
      if (h0 || h1) begin
        if (en0 && en1 && cnt > 0) chk("alternate", 32'(h1), 32'(!last_id));
        if (!(en0 && en1) && w && cnt > 0) chk("write_spacing", 32'(cyc - last_hs), 32'd2);
        last_id = h1;
        last_hs = cyc;
        cnt++;
        if (h0) begin k0++; d0 = 8'($urandom); end
        if (h1) begin k1++; d1 = 8'($urandom); end
      end
    end
    chk("stream_count", 32'(cnt), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          first, h0, h1;
    logic [DW-1:0] pre;
    for (int i = 0; i < 4; i++) begin
      ram_mem[i] = '0;
      mmem[i]    = '0;
    end
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    model_reset();

    // Reset state, with both requesters asking
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_ram_addr", 32'(ram_address), 32'd0);
    chk("rst_ram_din", 32'(ram_data_in), 32'd0);
    chk("rst_ram_we", 32'(ram_write_enable), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
    chk("rst_rsp1_rdata", 32'(rsp1_rdata), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    // Both valid from reset: writes 11/22 to addr 1/2, requester 0 first
    pair(1'b1, 2'd1, 8'h11, 1'b1, 2'd2, 8'h22, first);
    chk("first_grant_from_reset", 32'(first), 32'd0);
    pair(1'b0, 2'd1, 8'h00, 1'b0, 2'd2, 8'h00, first);
    idle(4);
    chk("readback0_11", 32'(rsp0_rdata), 32'h11);
    chk("readback1_22", 32'(rsp1_rdata), 32'h22);

    // Write AA then read back on requester 0
    req_one(1'b0, 1'b1, 2'd0, 8'hAA);
    req_one(1'b0, 1'b0, 2'd0, 8'h00);
    idle(4);
    chk("readback_AA", 32'(rsp0_rdata), 32'hAA);

    // Both stream 8 reads; grants must alternate
    stream(8, 1'b1, 1'b1, 1'b0, 2'($urandom), 2'($urandom));

    // Requester 1 alone: writes to addr 3,0,1,2, one every two cycles
    stream(4, 1'b0, 1'b1, 1'b1, 2'd0, 2'd3);

    // Read by 0 while 1's write to the same address waits; pre-write value returned
    pre = mmem[1];
    pair(1'b0, 2'd1, 8'h00, 1'b1, 2'd1, 8'h5A, first);
    chk("read_wins_tie", 32'(first), 32'd0);
    idle(2);
    chk("read_before_write", 32'(rsp0_rdata), 32'(pre));

    // Reset asserted during CAPTURE of a read
    req_one(1'b0, 1'b0, 2'd2, 8'h00);
    idle(1);
    @(posedge clk);
    #2;
    cyc++;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ram_addr", 32'(ram_address), 32'd0);
    chk("midrst_ram_din", 32'(ram_data_in), 32'd0);
    chk("midrst_ram_we", 32'(ram_write_enable), 32'd0);
    chk("midrst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
    chk("midrst_rsp1_rdata", 32'(rsp1_rdata), 32'd0);
    chk("midrst_ready0", 32'(req0_ready), 32'd0);
    chk("midrst_ready1", 32'(req1_ready), 32'd0);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    req_one(1'b1, 1'b0, 2'd1, 8'h00);
    idle(4);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), h0, h1);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
